// File: rtl/uart_byte_rx_pkg.sv
// uart_byte_rx_pkg: receiver state encoding and default bit timing shared by the UART receive slice.
package uart_byte_rx_pkg;
    localparam int DEFAULT_CLKS_PER_BIT = 868;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_e;
endpackage

// File: rtl/uart_byte_rx_bit_sync.sv
// bit_sync: multi-flop synchronizer for an asynchronous level; flops reset to 1 (idle line).
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ff <= '1;
        else        ff <= {ff[STAGES-2:0], d};
    end
    assign q = ff[STAGES-1];
endmodule

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 UART byte receiver with mid-bit sampling, stop-bit error detection and break hold-off.
module uart_byte_rx
    import uart_byte_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rxd,
    output logic [7:0] frame_data_out,
    output logic       frame_data_ena,
    output logic       frame_err,
    output logic       rx_busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic            rxd_s;
    rx_state_e       state_q, state_d;
    logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shreg_q, shreg_d, data_d;
    logic            ena_d, err_d;

    bit_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (uart_rxd),
        .q     (rxd_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            clk_cnt_q      <= '0;
            bit_cnt_q      <= '0;
            shreg_q        <= '0;
            frame_data_out <= '0;
            frame_data_ena <= 1'b0;
            frame_err      <= 1'b0;
        end else begin
            state_q        <= state_d;
            clk_cnt_q      <= clk_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            shreg_q        <= shreg_d;
            frame_data_out <= data_d;
            frame_data_ena <= ena_d;
            frame_err      <= err_d;
        end
    end

    // Counter runs freely inside a bit and is cleared on every sample point and state change.
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q + 1'b1;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        data_d    = frame_data_out;
        ena_d     = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                state_d   = rxd_s ? IDLE : START;
            end
            START: begin
                if (clk_cnt_q == HALF) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = rxd_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (clk_cnt_q == LAST) begin
                    clk_cnt_d          = '0;
                    shreg_d[bit_cnt_q] = rxd_s;
                    bit_cnt_d          = bit_cnt_q + 3'd1;
                    state_d            = (bit_cnt_q == 3'd7) ? STOP : DATA;
                end
            end
            STOP: begin
                if (clk_cnt_q == LAST) begin
                    clk_cnt_d = '0;
                    data_d    = rxd_s ? shreg_q : frame_data_out;
                    ena_d     = rxd_s;
                    err_d     = !rxd_s;
                    state_d   = rxd_s ? IDLE : BREAK;
                end
            end
            BREAK: begin
                clk_cnt_d = '0;
                state_d   = rxd_s ? IDLE : BREAK;
            end
            default: begin
                clk_cnt_d = '0;
                state_d   = IDLE;
            end
        endcase
    end

    assign rx_busy = (state_q != IDLE);
endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx: randomized and directed 8N1 stimulus checked cycle-by-cycle against a frame-level timing model.
`timescale 1ns/1ps
module tb_uart_byte_rx;
    import uart_byte_rx_pkg::*;

    localparam int CPB  = 16;
    localparam int SYNC = 2;
    // Strobe cycle after the start edge: synchronizer, idle detect, half bit, then 8 data + stop bits.
    localparam int LAT  = SYNC + 1 + CPB / 2 + 9 * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       uart_rxd = 1'b1;
    logic [7:0] frame_data_out;
    logic       frame_data_ena, frame_err, rx_busy;

    int checks = 0, errors = 0, cyc = 0;
    int ena_cnt = 0, err_cnt = 0, last_ena_cyc = -1;
    logic [7:0] model_last = 8'h00;
    int         exp_cyc_q[$];
    logic [7:0] exp_dat_q[$];
    int         err_cyc_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_byte_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .uart_rxd       (uart_rxd),
        .frame_data_out (frame_data_out),
        .frame_data_ena (frame_data_ena),
        .frame_err      (frame_err),
        .rx_busy        (rx_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_val, input realtime bitp);
        if (stop_val) begin
            exp_cyc_q.push_back(cyc + LAT);
            exp_dat_q.push_back(b);
        end else begin
            err_cyc_q.push_back(cyc + LAT);
        end
        uart_rxd = 1'b0;
        #(bitp);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            #(bitp);
        end
        uart_rxd = stop_val;
        #(bitp);
    endtask

    always @(negedge clk) begin : compare
        logic exp_e, exp_r;
        if (!rst_n) begin
            model_last = 8'h00;
            check("rst_data", frame_data_out, 8'h00);
            check("rst_ena", frame_data_ena, 1'b0);
            check("rst_err", frame_err, 1'b0);
            check("rst_busy", rx_busy, 1'b0);
        end else begin
            exp_e = exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc;
            exp_r = err_cyc_q.size() > 0 && err_cyc_q[0] == cyc;
            if (exp_e) begin
                model_last = exp_dat_q.pop_front();
                void'(exp_cyc_q.pop_front());
            end
            if (exp_r) void'(err_cyc_q.pop_front());
            check("ena", frame_data_ena, exp_e);
            check("err", frame_err, exp_r);
            check("data", frame_data_out, model_last);
            check("ena_err_excl", frame_data_ena && frame_err, 1'b0);
            if (frame_data_ena) begin
                ena_cnt++;
                last_ena_cyc = cyc;
            end
            if (frame_err) err_cnt++;
        end
    end

    initial begin
        int t0, s0, e0, r0;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(5);
        t0 = cyc;
        send_byte(8'hEB, 1'b1, 160.0);
        check("eb_latency", last_ena_cyc - t0, 155);
        check("eb_value", frame_data_out, 8'hEB);
        wait_clk(20);
        send_byte(8'h9C, 1'b1, 160.0);
        check("9c_value", frame_data_out, 8'h9C);
        wait_clk(20);
        e0 = ena_cnt;
        uart_rxd = 1'b0;
        wait_clk(5);
        uart_rxd = 1'b1;
        wait_clk(8);
        check("false_start_busy", rx_busy, 1'b0);
        check("false_start_nostrobe", ena_cnt - e0, 0);
        wait_clk(5);
        send_byte(8'h55, 1'b1, 160.0);
        check("55_value", frame_data_out, 8'h55);
        wait_clk(10);
        e0 = ena_cnt;
        r0 = err_cnt;
        send_byte(8'hA5, 1'b0, 160.0);
        wait_clk(40);
        check("break_one_err", err_cnt - r0, 1);
        check("break_no_ena", ena_cnt - e0, 0);
        check("break_data_kept", frame_data_out, 8'h55);
        check("break_state", 32'(dut.state_q), 32'(BREAK));
        check("break_busy", rx_busy, 1'b1);
        uart_rxd = 1'b1;
        wait_clk(10);
        check("break_exit", rx_busy, 1'b0);
        e0 = ena_cnt;
        s0 = cyc;
        for (int i = 0; i < 10; i++) send_byte(8'(i), 1'b1, 160.0);
        wait_clk(10);
        check("stream_count", ena_cnt - e0, 10);
        check("stream_spacing", last_ena_cyc - (s0 + 155), 1440);
        check("stream_last", frame_data_out, 8'h09);
        e0 = ena_cnt;
        uart_rxd = 1'b0;
        wait_clk(CPB);
        uart_rxd = 1'b1;
        wait_clk(CPB * 4 + CPB / 2);
        rst_n = 1'b0;
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(200);
        check("reset_discard", ena_cnt - e0, 0);
        send_byte(8'h3C, 1'b1, 160.0);
        check("3c_value", frame_data_out, 8'h3C);
        wait_clk(10);
        send_byte(8'h81, 1'b1, 155.0);
        wait_clk(10);
        check("skew_fast", frame_data_out, 8'h81);
        send_byte(8'h81, 1'b1, 165.0);
        wait_clk(10);
        check("skew_slow", frame_data_out, 8'h81);
        for (int i = 0; i < 8; i++) begin
            send_byte(8'($urandom_range(255)), 1'b1, 160.0);
            wait_clk($urandom_range(20));
        end
        wait_clk(200);
        check("pending_strobes", exp_cyc_q.size(), 0);
        check("pending_errs", err_cyc_q.size(), 0);
        check("total_strobes", ena_cnt, 24);
        check("total_errs", err_cnt, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
